// File: rtl/rsp_s1_pkg.sv
// rtl/rsp_s1_pkg.sv - shared state encoding and FIFO word field helpers for the rsp stage-1 packer
package rsp_s1_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } pack_state_t;

    // The last flag rides directly above the payload in each FIFO word.
    function automatic int last_bit(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/rsp_s1_idle_timer.sv
// rtl/rsp_s1_idle_timer.sv - idle cycle counter that pulses expire after TIMEOUT enabled cycles
module rsp_s1_idle_timer #(
    parameter  int TIMEOUT = 16,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    assign expire = enable & (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rsp_s1_word_packer.sv
// rtl/rsp_s1_word_packer.sv - packs RATIO narrow FWFT FIFO words into one wide valid/ready beat
// Optional partial-beat flush timer enabled by defining RSP_S1_PACK_TIMEOUT_EN.
module rsp_s1_word_packer
    import rsp_s1_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int RATIO     = 4,
    parameter  int TIMEOUT   = 16,
    localparam int LANE_BITS = $clog2(RATIO)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W:0]         fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_pop,
    output logic [DATA_W*RATIO-1:0] out_data,
    output logic [RATIO-1:0]        out_keep,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int                 LAST_BIT = last_bit(DATA_W);
    localparam logic [LANE_BITS-1:0] LANE_MAX = LANE_BITS'(RATIO - 1);

    pack_state_t             state_q, state_n;
    logic [LANE_BITS-1:0]    lane_q, lane_n;
    logic [DATA_W*RATIO-1:0] data_q, data_n;
    logic [RATIO-1:0]        keep_q, keep_n;
    logic                    last_q, last_n;
    logic                    valid_q, valid_n;
    logic [DATA_W-1:0]       word;
    logic                    word_last;
    logic                    timer_expire;

    assign word      = fifo_dout[DATA_W-1:0];
    assign word_last = fifo_dout[LAST_BIT];
    assign fifo_pop  = ~fifo_empty & ((state_q == ST_FILL) | out_ready);

`ifdef RSP_S1_PACK_TIMEOUT_EN
    rsp_s1_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (fifo_pop),
        .enable ((state_q == ST_FILL) && (lane_q != '0) && !fifo_pop),
        .expire (timer_expire)
    );
`else
    // TIMEOUT only matters with the flush timer built in.
    assign timer_expire = 1'b0 & (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            lane_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            lane_q  <= lane_n;
            data_q  <= data_n;
            keep_q  <= keep_n;
            last_q  <= last_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        lane_n  = lane_q;
        data_n  = data_q;
        keep_n  = keep_q;
        last_n  = last_q;
        valid_n = valid_q;
        case (state_q)
            ST_FILL: begin
                if (fifo_pop) begin
                    data_n[lane_q*DATA_W +: DATA_W] = word;
                    keep_n[lane_q]                  = 1'b1;
                    if ((lane_q == LANE_MAX) || word_last) begin
                        last_n  = word_last;
                        valid_n = 1'b1;
                        lane_n  = '0;
                        state_n = ST_EMIT;
                    end else begin
                        lane_n = lane_q + 1'b1;
                    end
                end else if (timer_expire) begin
                    last_n  = 1'b0;
                    valid_n = 1'b1;
                    lane_n  = '0;
                    state_n = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (fifo_pop) begin
                        // Back-to-back: the handshake cycle also seeds lane 0 of the next beat.
                        data_n              = '0;
                        data_n[DATA_W-1:0]  = word;
                        keep_n              = RATIO'(1);
                        if (word_last) begin
                            last_n  = 1'b1;
                            valid_n = 1'b1;
                            lane_n  = '0;
                            state_n = ST_EMIT;
                        end else begin
                            last_n  = 1'b0;
                            valid_n = 1'b0;
                            lane_n  = LANE_BITS'(1);
                            state_n = ST_FILL;
                        end
                    end else begin
                        data_n  = '0;
                        keep_n  = '0;
                        last_n  = 1'b0;
                        valid_n = 1'b0;
                        lane_n  = '0;
                        state_n = ST_FILL;
                    end
                end
            end
            default: begin
                state_n = ST_FILL;
            end
        endcase
    end

    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_rsp_s1_word_packer.sv
// tb/tb_rsp_s1_word_packer.sv - directed self-checking bench for rsp_s1_word_packer
module tb_rsp_s1_word_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rsp_s1_word_packer #(
        .DATA_W  (8),
        .RATIO   (4),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // FWFT FIFO model
    logic [8:0] mem [0:63];
    int wr = 0;
    int rd = 0;
    assign fifo_empty = (rd == wr);
    assign fifo_dout  = mem[rd[5:0]];

    always @(posedge clk) begin
        if (fifo_pop) rd <= rd + 1;
    end

    // Beat capture
    int          cyc = 0;
    int          nb = 0;
    int          stall = 0;
    int          last_pop = 0;
    logic [31:0] bd [0:31];
    logic [3:0]  bk [0:31];
    logic        bl [0:31];
    int          bt [0:31];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                bd[nb] <= out_data;
                bk[nb] <= out_keep;
                bl[nb] <= out_last;
                bt[nb] <= cyc;
                nb     <= nb + 1;
            end
            if (fifo_pop) last_pop <= cyc;
            if (!fifo_empty && out_ready && !fifo_pop) stall <= stall + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic last, input logic [7:0] d);
        mem[wr[5:0]] = {last, d};
        wr++;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k = 0;
        while (nb < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(nb), 64'(n));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] exp3 [0:2];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data",  64'(out_data),  64'(0));
        check("rst_keep",  64'(out_keep),  64'(0));
        check("rst_last",  64'(out_last),  64'(0));
        check("rst_pop",   64'(fifo_pop),  64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Full beat, last on 4th word
        push(1'b0, 8'h11); push(1'b0, 8'h22); push(1'b0, 8'h33); push(1'b1, 8'h44);
        wait_beats("t1_wait", 1, 20);
        check("t1_data", 64'(bd[0]), 64'h44332211);
        check("t1_keep", 64'(bk[0]), 64'hF);
        check("t1_last", 64'(bl[0]), 64'(1));
        check("t1_latency", 64'(bt[0] - last_pop), 64'(1));
        idle(2);

        // Short packet then next packet begins at lane 0
        push(1'b0, 8'hA1); push(1'b1, 8'hA2);
        push(1'b0, 8'hB1); push(1'b0, 8'hB2); push(1'b0, 8'hB3); push(1'b1, 8'hB4);
        wait_beats("t2_wait", 3, 30);
        check("t2_short_data", 64'(bd[1]), 64'h0000A2A1);
        check("t2_short_keep", 64'(bk[1]), 64'h3);
        check("t2_short_last", 64'(bl[1]), 64'(1));
        check("t2_next_data",  64'(bd[2]), 64'hB4B3B2B1);
        check("t2_next_keep",  64'(bk[2]), 64'hF);
        check("t2_spacing",    64'(bt[2] - bt[1]), 64'(4));
        idle(2);

        // 12-word stream, full throughput
        for (int i = 1; i <= 12; i++) push(i == 12, 8'(i));
        wait_beats("t3_wait", 6, 60);
        exp3[0] = 32'h04030201;
        exp3[1] = 32'h08070605;
        exp3[2] = 32'h0C0B0A09;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_data%0d", k), 64'(bd[3+k]), 64'(exp3[k]));
            check($sformatf("t3_last%0d", k), 64'(bl[3+k]), 64'(k == 2));
            if (k > 0) check($sformatf("t3_gap%0d", k), 64'(bt[3+k] - bt[2+k]), 64'(4));
        end
        idle(2);

        // Backpressure while FIFO non-empty
        out_ready = 1'b0;
        push(1'b0, 8'hC1); push(1'b0, 8'hC2); push(1'b0, 8'hC3); push(1'b0, 8'hC4);
        push(1'b1, 8'hD1);
        begin
            int k = 0;
            while (!out_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        check("t4_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_pop",  64'(fifo_pop), 64'(0));
            check("t4_hold_data", 64'(out_data), 64'hC4C3C2C1);
            @(negedge clk);
        end
        check("t4_no_beat", 64'(nb), 64'(6));
        out_ready = 1'b1;
        #1;
        check("t4_pop_on_ready", 64'(fifo_pop), 64'(1));
        wait_beats("t4_wait", 8, 10);
        check("t4_data",   64'(bd[6]), 64'hC4C3C2C1);
        check("t4_last",   64'(bl[6]), 64'(0));
        check("t4_d1_data", 64'(bd[7]), 64'h000000D1);
        check("t4_d1_keep", 64'(bk[7]), 64'h1);
        check("t4_d1_last", 64'(bl[7]), 64'(1));
        check("t4_d1_b2b",  64'(bt[7] - bt[6]), 64'(1));
        idle(2);

        // Mid-packet reset
        push(1'b0, 8'hE1); push(1'b0, 8'hE2);
        idle(4);
        check("t5_partial_valid", 64'(out_valid), 64'(0));
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(out_valid), 64'(0));
        check("t5_rst_data",  64'(out_data),  64'(0));
        check("t5_rst_keep",  64'(out_keep),  64'(0));
        check("t5_rst_last",  64'(out_last),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(1'b0, 8'hF1); push(1'b0, 8'hF2); push(1'b0, 8'hF3); push(1'b1, 8'hF4);
        wait_beats("t5_wait", 9, 20);
        check("t5_data", 64'(bd[8]), 64'hF4F3F2F1);
        check("t5_keep", 64'(bk[8]), 64'hF);
        idle(2);

        // Idle partial beat
        push(1'b0, 8'h61); push(1'b0, 8'h62); push(1'b0, 8'h63);
        idle(25);
`ifdef RSP_S1_PACK_TIMEOUT_EN
        check("t6_flush_count", 64'(nb), 64'(10));
        check("t6_flush_data",  64'(bd[9]), 64'h00636261);
        check("t6_flush_keep",  64'(bk[9]), 64'h7);
        check("t6_flush_last",  64'(bl[9]), 64'(0));
`else
        check("t6_no_flush", 64'(nb), 64'(9));
        check("t6_no_valid", 64'(out_valid), 64'(0));
        push(1'b1, 8'h64);
        wait_beats("t6_wait", 10, 20);
        check("t6_data", 64'(bd[9]), 64'h64636261);
        check("t6_keep", 64'(bk[9]), 64'hF);
        check("t6_last", 64'(bl[9]), 64'(1));
`endif

        check("no_pop_gap", 64'(stall), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
